// File: rtl/sopc_mem_arbiter_pkg.sv
// Shared types and constants for the SOPC memory arbiter and its reusable
// request arbiter.
package sopc_mem_arbiter_pkg;

    typedef enum logic [2:0] {
        ARB_IDLE   = 3'd0,
        ARB_WAIT   = 3'd1,
        ARB_ACCESS = 3'd2,
        ARB_LAT    = 3'd3,
        ARB_DONE   = 3'd4
    } arb_state_e;

    localparam logic ARB_FIXED = 1'b0;
    localparam logic ARB_RR    = 1'b1;

    function automatic int sel_width(input int dw);
        return dw / 8;
    endfunction

endpackage

// File: rtl/sopc_mem_arbiter_if.sv
// Bus bundle between N requesting masters, the arbiter and one memory macro.
// The arbiter uses the slave modport; masters plus memory sit on the master side.
interface sopc_mem_arbiter_if
    import sopc_mem_arbiter_pkg::*;
#(
    parameter int NUM_M = 2,
    parameter int AW    = 32,
    parameter int DW    = 32
);
    localparam int SW = sel_width(DW);

    logic [NUM_M-1:0]    m_req;
    logic [NUM_M-1:0]    m_we;
    logic [NUM_M*AW-1:0] m_addr;
    logic [NUM_M*SW-1:0] m_sel;
    logic [NUM_M*DW-1:0] m_wdata;
    logic [NUM_M-1:0]    m_gnt;
    logic [NUM_M-1:0]    m_rvalid;
    logic [DW-1:0]       m_rdata;

    logic                s_ce;
    logic                s_we;
    logic [AW-1:0]       s_addr;
    logic [SW-1:0]       s_sel;
    logic [DW-1:0]       s_wdata;
    logic [DW-1:0]       s_rdata;

    modport slave (
        input  m_req, m_we, m_addr, m_sel, m_wdata, s_rdata,
        output m_gnt, m_rvalid, m_rdata, s_ce, s_we, s_addr, s_sel, s_wdata
    );

    modport master (
        output m_req, m_we, m_addr, m_sel, m_wdata, s_rdata,
        input  m_gnt, m_rvalid, m_rdata, s_ce, s_we, s_addr, s_sel, s_wdata
    );

endinterface

// File: rtl/sopc_mem_arbiter_rr.sv
// Combinational request arbiter: fixed priority (lowest index) or round-robin
// starting at ptr. Returns a one-hot grant and the binary winner index.
module mem_rr_arbiter
    import sopc_mem_arbiter_pkg::*;
#(
    parameter int N  = 2,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    input  logic          mode,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx
);

    // Scan from the farthest candidate down so the nearest one is assigned last.
    always_comb begin
        idx = '0;
        gnt = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (mode == ARB_RR) begin
                if (req[(int'(ptr) + k) % N]) idx = IW'((int'(ptr) + k) % N);
            end else if (req[k]) begin
                idx = IW'(k);
            end
        end
        if (|req) gnt[idx] = 1'b1;
    end

endmodule

// File: rtl/sopc_mem_arbiter.sv
// N-master to single-port memory arbiter: one outstanding transaction,
// optional wait states before the access and optional registered read latency.
module sopc_mem_arbiter
    import sopc_mem_arbiter_pkg::*;
#(
    parameter int NUM_M    = 2,
    parameter int AW       = 32,
    parameter int DW       = 32,
    parameter int ARB_MODE = 0,
    parameter int WAIT_CYC = 0,
    parameter int RD_LAT   = 0
) (
    input logic               clk,
    input logic               rst_n,
    sopc_mem_arbiter_if.slave bus
);

    localparam int   SW   = sel_width(DW);
    localparam int   IW   = (NUM_M > 1) ? $clog2(NUM_M) : 1;
    localparam logic MODE = (ARB_MODE == 1) ? ARB_RR : ARB_FIXED;

    arb_state_e    state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [IW-1:0] ptr_q, ptr_d;
    logic [IW-1:0] owner_q, owner_d;
    logic          we_q, we_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [SW-1:0] sel_q, sel_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [DW-1:0] rdata_q, rdata_d;

    logic [NUM_M-1:0] arb_gnt;
    logic [IW-1:0]    arb_idx;

    mem_rr_arbiter #(.N(NUM_M), .IW(IW)) u_arb (
        .req  (bus.m_req),
        .ptr  (ptr_q),
        .mode (MODE),
        .gnt  (arb_gnt),
        .idx  (arb_idx)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ARB_IDLE;
            cnt_q   <= '0;
            ptr_q   <= '0;
            owner_q <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            sel_q   <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            sel_q   <= sel_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        we_d    = we_q;
        addr_d  = addr_q;
        sel_d   = sel_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        case (state_q)
            ARB_IDLE: begin
                if (|bus.m_req) begin
                    owner_d = arb_idx;
                    we_d    = bus.m_we[arb_idx];
                    addr_d  = bus.m_addr[int'(arb_idx)*AW +: AW];
                    sel_d   = bus.m_sel[int'(arb_idx)*SW +: SW];
                    wdata_d = bus.m_wdata[int'(arb_idx)*DW +: DW];
                    ptr_d   = (int'(arb_idx) == NUM_M - 1) ? '0 : arb_idx + IW'(1);
                    if (WAIT_CYC > 0) begin
                        state_d = ARB_WAIT;
                        cnt_d   = 4'(WAIT_CYC - 1);
                    end else begin
                        state_d = ARB_ACCESS;
                    end
                end
            end
            ARB_WAIT: begin
                if (cnt_q == 4'd0) state_d = ARB_ACCESS;
                else               cnt_d   = cnt_q - 4'd1;
            end
            ARB_ACCESS: begin
                if (RD_LAT == 0) begin
                    if (!we_q) rdata_d = bus.s_rdata;
                    state_d = ARB_DONE;
                end else begin
                    state_d = ARB_LAT;
                end
            end
            ARB_LAT: begin
                if (!we_q) rdata_d = bus.s_rdata;
                state_d = ARB_DONE;
            end
            ARB_DONE: state_d = ARB_IDLE;
            default:  state_d = ARB_IDLE;
        endcase
    end

    // Grant is gated by reset so every output reads 0 while rst_n is low.
    always_comb begin
        bus.m_gnt    = '0;
        bus.m_rvalid = '0;
        bus.s_ce     = 1'b0;
        bus.s_we     = 1'b0;
        bus.s_addr   = '0;
        bus.s_sel    = '0;
        bus.s_wdata  = '0;
        if (state_q == ARB_IDLE && rst_n) bus.m_gnt = arb_gnt;
        if (state_q == ARB_DONE) bus.m_rvalid[owner_q] = 1'b1;
        if (state_q == ARB_ACCESS) begin
            bus.s_ce    = 1'b1;
            bus.s_we    = we_q;
            bus.s_addr  = addr_q;
            bus.s_sel   = sel_q;
            bus.s_wdata = wdata_q;
        end
    end

    assign bus.m_rdata = rdata_q;

endmodule

// File: tb/tb_sopc_mem_arbiter.sv
// Directed bench for sopc_mem_arbiter: four instances cover default timing,
// wait states with registered reads, fixed priority and round-robin.
module tb_sopc_mem_arbiter;

    logic clk = 1'b0;
    logic rst_n;
    logic rst1_n;
    int   total;
    int   bad;

    always #5 clk = ~clk;

    sopc_mem_arbiter_if #(.NUM_M(2)) b0 ();
    sopc_mem_arbiter_if #(.NUM_M(2)) b1 ();
    sopc_mem_arbiter_if #(.NUM_M(3)) b2 ();
    sopc_mem_arbiter_if #(.NUM_M(3)) b3 ();

    sopc_mem_arbiter #(.NUM_M(2)) u0 (.clk(clk), .rst_n(rst_n), .bus(b0.slave));
    sopc_mem_arbiter #(.NUM_M(2), .ARB_MODE(1), .WAIT_CYC(2), .RD_LAT(1))
        u1 (.clk(clk), .rst_n(rst1_n), .bus(b1.slave));
    sopc_mem_arbiter #(.NUM_M(3)) u2 (.clk(clk), .rst_n(rst_n), .bus(b2.slave));
    sopc_mem_arbiter #(.NUM_M(3), .ARB_MODE(1)) u3 (.clk(clk), .rst_n(rst_n), .bus(b3.slave));

    // u0 memory: combinational ROM-like lookup
    assign b0.s_rdata = (b0.s_addr == 32'h10) ? 32'hDEADBEEF :
                        (b0.s_addr == 32'h20) ? 32'hCAFEF00D : 32'h0;

    // u1 memory: byte-enabled RAM with registered read, cleared only by rst_n
    logic [31:0] mem1 [0:15];
    logic [31:0] rd1;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) mem1[i] <= '0;
            rd1 <= '0;
        end else if (b1.s_ce) begin
            if (b1.s_we) begin
                for (int b = 0; b < 4; b++)
                    if (b1.s_sel[b]) mem1[b1.s_addr[5:2]][b*8 +: 8] <= b1.s_wdata[b*8 +: 8];
            end else begin
                rd1 <= mem1[b1.s_addr[5:2]];
            end
        end
    end
    assign b1.s_rdata = rd1;
    assign b2.s_rdata = 32'h0;
    assign b3.s_rdata = 32'h0;

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic test_reset();
        #2;
        total++; if ({b0.m_gnt, b0.m_rvalid, b0.s_ce, b0.s_we, b0.s_sel} !== '0) begin bad++; $display("FAIL rst_ctl got=%h exp=0", {b0.m_gnt, b0.m_rvalid, b0.s_ce, b0.s_we, b0.s_sel}); end
        total++; if ({b0.s_addr, b0.s_wdata, b0.m_rdata} !== '0) begin bad++; $display("FAIL rst_data got=%h exp=0", {b0.s_addr, b0.s_wdata, b0.m_rdata}); end
        nxt(); nxt();
        rst_n = 1'b1; rst1_n = 1'b1;
        smp();
        total++; if ({b0.m_gnt, b0.s_ce, b1.m_gnt, b1.s_ce} !== '0) begin bad++; $display("FAIL idle_quiet got=%h exp=0", {b0.m_gnt, b0.s_ce, b1.m_gnt, b1.s_ce}); end
        nxt();
    endtask

    task automatic test_single_read();
        b0.m_req = 2'b10; b0.m_we = 2'b00; b0.m_addr[32 +: 32] = 32'h10; b0.m_sel[4 +: 4] = 4'hF;
        smp();
        total++; if (b0.m_gnt !== 2'b10) begin bad++; $display("FAIL sr_gnt got=%b exp=10", b0.m_gnt); end
        total++; if (b0.s_ce !== 1'b0) begin bad++; $display("FAIL sr_ce_T got=%b exp=0", b0.s_ce); end
        nxt(); b0.m_req = 2'b00; smp();
        total++; if ({b0.s_ce, b0.s_we} !== 2'b10) begin bad++; $display("FAIL sr_ce got=%b exp=10", {b0.s_ce, b0.s_we}); end
        total++; if (b0.s_addr !== 32'h10) begin bad++; $display("FAIL sr_addr got=%h exp=10", b0.s_addr); end
        total++; if ({b0.m_gnt, b0.m_rvalid} !== 4'b0000) begin bad++; $display("FAIL sr_acc_quiet got=%b exp=0000", {b0.m_gnt, b0.m_rvalid}); end
        nxt(); smp();
        total++; if (b0.m_rvalid !== 2'b10) begin bad++; $display("FAIL sr_rvalid got=%b exp=10", b0.m_rvalid); end
        total++; if (b0.m_rdata !== 32'hDEADBEEF) begin bad++; $display("FAIL sr_rdata got=%h exp=deadbeef", b0.m_rdata); end
        total++; if (b0.s_ce !== 1'b0) begin bad++; $display("FAIL sr_ce_done got=%b exp=0", b0.s_ce); end
        nxt(); smp();
        total++; if (b0.m_rvalid !== 2'b00) begin bad++; $display("FAIL sr_rvalid_pulse got=%b exp=00", b0.m_rvalid); end
        nxt();
    endtask

    task automatic test_write_read();
        logic        we_t [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        logic [3:0]  sel_t[4] = '{4'b0011, 4'b1111, 4'b1111, 4'b1111};
        logic [31:0] wd_t [4] = '{32'h12345678, 32'h0, 32'hFFFFFFFF, 32'h0};
        logic [31:0] rd_t [4] = '{32'h0, 32'h00005678, 32'h00005678, 32'hFFFFFFFF};
        for (int v = 0; v < 4; v++) begin
            b1.m_req = 2'b01; b1.m_we[0] = we_t[v]; b1.m_addr[0 +: 32] = 32'h44;
            b1.m_sel[0 +: 4] = sel_t[v]; b1.m_wdata[0 +: 32] = wd_t[v];
            smp();
            total++; if (b1.m_gnt !== 2'b01) begin bad++; $display("FAIL wr%0d_gnt got=%b exp=01", v, b1.m_gnt); end
            nxt(); b1.m_req = 2'b00; smp();
            total++; if (b1.s_ce !== 1'b0) begin bad++; $display("FAIL wr%0d_wait1 got=%b exp=0", v, b1.s_ce); end
            nxt(); smp();
            total++; if (b1.s_ce !== 1'b0) begin bad++; $display("FAIL wr%0d_wait2 got=%b exp=0", v, b1.s_ce); end
            nxt(); smp();
            total++; if ({b1.s_ce, b1.s_we, b1.s_sel} !== {1'b1, we_t[v], sel_t[v]}) begin bad++; $display("FAIL wr%0d_acc got=%b exp=%b", v, {b1.s_ce, b1.s_we, b1.s_sel}, {1'b1, we_t[v], sel_t[v]}); end
            total++; if ({b1.s_addr, b1.s_wdata} !== {32'h44, wd_t[v]}) begin bad++; $display("FAIL wr%0d_acc_data got=%h exp=%h", v, {b1.s_addr, b1.s_wdata}, {32'h44, wd_t[v]}); end
            nxt(); smp();
            total++; if ({b1.s_ce, b1.m_rvalid} !== 3'b000) begin bad++; $display("FAIL wr%0d_lat got=%b exp=000", v, {b1.s_ce, b1.m_rvalid}); end
            nxt(); smp();
            total++; if (b1.m_rvalid !== 2'b01) begin bad++; $display("FAIL wr%0d_rvalid got=%b exp=01", v, b1.m_rvalid); end
            total++; if (b1.m_rdata !== rd_t[v]) begin bad++; $display("FAIL wr%0d_rdata got=%h exp=%h", v, b1.m_rdata, rd_t[v]); end
            nxt();
        end
    endtask

    task automatic test_fixed_prio();
        logic [2:0] eg, ev;
        b2.m_req = 3'b101;
        for (int k = 0; k < 9; k++) begin
            eg = (k % 3 == 0) ? 3'b001 : 3'b000;
            ev = (k % 3 == 2) ? 3'b001 : 3'b000;
            smp();
            total++; if (b2.m_gnt !== eg) begin bad++; $display("FAIL fp_gnt%0d got=%b exp=%b", k, b2.m_gnt, eg); end
            total++; if (b2.m_rvalid !== ev) begin bad++; $display("FAIL fp_rvalid%0d got=%b exp=%b", k, b2.m_rvalid, ev); end
            nxt();
        end
        b2.m_req = 3'b000;
        nxt();
    endtask

    task automatic test_round_robin();
        logic [2:0] eg, ev;
        b3.m_req = 3'b111;
        for (int k = 0; k < 18; k++) begin
            eg = (k % 3 == 0) ? 3'(1 << ((k / 3) % 3)) : 3'b000;
            ev = (k % 3 == 2) ? 3'(1 << ((k / 3) % 3)) : 3'b000;
            smp();
            total++; if (b3.m_gnt !== eg) begin bad++; $display("FAIL rr_gnt%0d got=%b exp=%b", k, b3.m_gnt, eg); end
            total++; if (b3.m_rvalid !== ev) begin bad++; $display("FAIL rr_rvalid%0d got=%b exp=%b", k, b3.m_rvalid, ev); end
            nxt();
        end
        b3.m_req = 3'b000;
        nxt();
    endtask

    task automatic test_reset_midop();
        b1.m_req = 2'b01; b1.m_we = 2'b00; b1.m_addr[0 +: 32] = 32'h44; b1.m_sel[0 +: 4] = 4'hF;
        smp();
        total++; if (b1.m_gnt !== 2'b01) begin bad++; $display("FAIL rm_gnt got=%b exp=01", b1.m_gnt); end
        nxt(); b1.m_req = 2'b00;
        nxt(); nxt(); smp();
        total++; if (b1.s_ce !== 1'b1) begin bad++; $display("FAIL rm_acc got=%b exp=1", b1.s_ce); end
        nxt();
        rst1_n = 1'b0;
        #1;
        total++; if ({b1.m_gnt, b1.m_rvalid, b1.s_ce, b1.s_we, b1.s_sel} !== '0) begin bad++; $display("FAIL rm_ctl0 got=%h exp=0", {b1.m_gnt, b1.m_rvalid, b1.s_ce, b1.s_we, b1.s_sel}); end
        total++; if ({b1.m_rdata, b1.s_addr} !== '0) begin bad++; $display("FAIL rm_data0 got=%h exp=0", {b1.m_rdata, b1.s_addr}); end
        nxt();
        rst1_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            smp();
            total++; if ({b1.m_rvalid, b1.m_gnt} !== 4'b0000) begin bad++; $display("FAIL rm_after%0d got=%b exp=0000", k, {b1.m_rvalid, b1.m_gnt}); end
            nxt();
        end
        b1.m_req = 2'b11; b1.m_addr[32 +: 32] = 32'h0;
        smp();
        total++; if (b1.m_gnt !== 2'b01) begin bad++; $display("FAIL rm_ptr0 got=%b exp=01", b1.m_gnt); end
        nxt(); b1.m_req = 2'b00;
        nxt(); nxt(); nxt(); nxt(); smp();
        total++; if ({b1.m_rvalid, b1.m_rdata} !== {2'b01, 32'hFFFFFFFF}) begin bad++; $display("FAIL rm_done got=%h exp=%h", {b1.m_rvalid, b1.m_rdata}, {2'b01, 32'hFFFFFFFF}); end
        nxt();
    endtask

    task automatic test_back_to_back();
        b0.m_req = 2'b01; b0.m_we = 2'b00; b0.m_addr[0 +: 32] = 32'h20; b0.m_sel[0 +: 4] = 4'hF;
        smp();
        total++; if (b0.m_gnt !== 2'b01) begin bad++; $display("FAIL bb_gnt1 got=%b exp=01", b0.m_gnt); end
        nxt(); b0.m_req = 2'b00; smp();
        total++; if ({b0.s_ce, b0.s_addr} !== {1'b1, 32'h20}) begin bad++; $display("FAIL bb_acc1 got=%h exp=%h", {b0.s_ce, b0.s_addr}, {1'b1, 32'h20}); end
        nxt(); b0.m_req = 2'b01; b0.m_addr[0 +: 32] = 32'h10; b0.m_sel[0 +: 4] = 4'h0; smp();
        total++; if (b0.m_gnt !== 2'b00) begin bad++; $display("FAIL bb_no_gnt_done got=%b exp=00", b0.m_gnt); end
        total++; if ({b0.m_rvalid, b0.m_rdata} !== {2'b01, 32'hCAFEF00D}) begin bad++; $display("FAIL bb_done1 got=%h exp=%h", {b0.m_rvalid, b0.m_rdata}, {2'b01, 32'hCAFEF00D}); end
        nxt(); smp();
        total++; if ({b0.m_gnt, b0.m_rvalid} !== 4'b0100) begin bad++; $display("FAIL bb_gnt2 got=%b exp=0100", {b0.m_gnt, b0.m_rvalid}); end
        nxt(); b0.m_req = 2'b00; smp();
        total++; if ({b0.s_ce, b0.s_sel, b0.s_addr} !== {1'b1, 4'h0, 32'h10}) begin bad++; $display("FAIL bb_sel0 got=%h exp=%h", {b0.s_ce, b0.s_sel, b0.s_addr}, {1'b1, 4'h0, 32'h10}); end
        nxt(); smp();
        total++; if ({b0.m_rvalid, b0.m_rdata} !== {2'b01, 32'hDEADBEEF}) begin bad++; $display("FAIL bb_done2 got=%h exp=%h", {b0.m_rvalid, b0.m_rdata}, {2'b01, 32'hDEADBEEF}); end
        nxt();
    endtask

    initial begin
        total = 0; bad = 0;
        rst_n = 1'b0; rst1_n = 1'b0;
        b0.m_req = '0; b0.m_we = '0; b0.m_addr = '0; b0.m_sel = '0; b0.m_wdata = '0;
        b1.m_req = '0; b1.m_we = '0; b1.m_addr = '0; b1.m_sel = '0; b1.m_wdata = '0;
        b2.m_req = '0; b2.m_we = '0; b2.m_addr = '0; b2.m_sel = '0; b2.m_wdata = '0;
        b3.m_req = '0; b3.m_we = '0; b3.m_addr = '0; b3.m_sel = '0; b3.m_wdata = '0;
        test_reset();
        test_single_read();
        test_write_read();
        test_fixed_prio();
        test_round_robin();
        test_reset_midop();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
